cmd_addr_dly_seq: RTL and testbench

//  Parametrised delay-programming sequencer for DDR3 command/address output lanes.
//  - Accepts queued (lane, delay) writes via valid/ready.
//  - Produces per-lane one-hot ld_dly strobes plus shared dly_data, for the per-lane cmda_single instances.
//  - Supports broadcast writes and issues set_dly automatically at batch end.
//  - Keeps a shadow copy of every lane delay for readback.
//  - Sits between the sequencer/register interface and the command/address PHY lanes; clk is the PHY clk_div domain.

---
 rtl/cmd_addr_pkg.sv | 32 +++
 rtl/cmd_addr_dly_fifo.sv | 44 ++++
 rtl/cmd_addr_dly_seq.sv | 164 ++++++++++++++++
 tb/tb_cmd_addr_dly_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_addr_pkg.sv
// Shared lane map, broadcast code and FSM encoding for the cmd/addr delay sequencer.
package cmd_addr_pkg;

  localparam int ADDRESS_NUMBER_DEF = 15;
  localparam int BANK_NUMBER_DEF    = 3;
  localparam int CMD_NUMBER_DEF     = 5;
  localparam int LANE_AW_DEF        = 6;

  // Command lanes follow the bank lanes in this fixed order
  localparam int CMD_WE  = 0;
  localparam int CMD_RAS = 1;
  localparam int CMD_CAS = 2;
  localparam int CMD_CKE = 3;
  localparam int CMD_ODT = 4;

  localparam int LANE_BA0 = ADDRESS_NUMBER_DEF;
  localparam int LANE_WE  = LANE_BA0 + BANK_NUMBER_DEF + CMD_WE;
  localparam int LANE_RAS = LANE_BA0 + BANK_NUMBER_DEF + CMD_RAS;
  localparam int LANE_CAS = LANE_BA0 + BANK_NUMBER_DEF + CMD_CAS;
  localparam int LANE_CKE = LANE_BA0 + BANK_NUMBER_DEF + CMD_CKE;
  localparam int LANE_ODT = LANE_BA0 + BANK_NUMBER_DEF + CMD_ODT;

  localparam logic [LANE_AW_DEF-1:0] BCAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BCAST = 2'd2,
    ST_SET   = 2'd3
  } state_t;

endpackage

// File: rtl/cmd_addr_dly_fifo.sv
// Generic synchronous FIFO; read data is the head entry, visible combinationally.
// Latency 1 (push -> not empty); push must be gated by !full, pop by !empty.
module cmd_addr_dly_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  // Extra pointer MSB separates full (wrapped once) from empty
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level  = wr_ptr - rd_ptr;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cmd_addr_dly_seq.sv
// Queues (lane, delay) writes and replays them as one-hot ld_dly strobes plus set_dly.
// Accept -> strobe in 2 cycles, one strobe per cycle; req_ready drops while the queue is full.
module cmd_addr_dly_seq
  import cmd_addr_pkg::*;
#(
  parameter int ADDRESS_NUMBER = ADDRESS_NUMBER_DEF,
  parameter int BANK_NUMBER    = BANK_NUMBER_DEF,
  parameter int CMD_NUMBER     = CMD_NUMBER_DEF,
  parameter int DLY_WIDTH      = 8,
  parameter int LANE_AW        = LANE_AW_DEF,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          req_valid,
  output logic                                          req_ready,
  input  logic [LANE_AW-1:0]                            req_lane,
  input  logic [DLY_WIDTH-1:0]                          req_data,
  input  logic                                          req_last,
  input  logic                                          set_req,
  output logic [ADDRESS_NUMBER+BANK_NUMBER+CMD_NUMBER-1:0] ld_dly,
  output logic [DLY_WIDTH-1:0]                          dly_data,
  output logic                                          set_dly,
  output logic                                          busy,
  output logic                                          err_lane,
  input  logic [LANE_AW-1:0]                            rd_lane,
  output logic [DLY_WIDTH-1:0]                          rd_data
);

  localparam int NUM_LINES = ADDRESS_NUMBER + BANK_NUMBER + CMD_NUMBER;
  localparam int CW        = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int FAW       = $clog2(FIFO_DEPTH);
  localparam int FW        = 1 + LANE_AW + DLY_WIDTH;
  localparam logic [LANE_AW-1:0]   LANE_LIMIT = LANE_AW'(NUM_LINES);
  localparam logic [CW-1:0]        CNT_LAST   = CW'(NUM_LINES - 1);
  localparam logic [NUM_LINES-1:0] LANE0      = NUM_LINES'(1);

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FAW:0]         fifo_level;
  logic [FW-1:0]        head;
  logic                 head_last;
  logic [LANE_AW-1:0]   head_lane;
  logic [DLY_WIDTH-1:0] head_data;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 set_pend_q, set_pend_d, pend_eff, take_set;
  logic                 bcast_end, err_set, sh_we, set_d, busy_d;
  logic [CW-1:0]        sh_idx;
  logic [DLY_WIDTH-1:0] data_d;
  logic [NUM_LINES-1:0] ld_d;
  logic [DLY_WIDTH-1:0] shadow [NUM_LINES];

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid & req_ready;
  assign {head_last, head_lane, head_data} = head;

  cmd_addr_dly_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (fifo_push),
    .wr_dat ({req_last, req_lane, req_data}),
    .pop    (fifo_pop),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign pend_eff  = set_pend_q | set_req;
  assign bcast_end = (state_q == ST_BCAST) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    data_d   = dly_data;
    set_d    = 1'b0;
    fifo_pop = 1'b0;
    err_set  = 1'b0;
    take_set = 1'b0;
    sh_we    = 1'b0;
    sh_idx   = '0;
    if ((state_q == ST_BCAST) && !bcast_end) begin
      cnt_d  = cnt_q + CW'(1);
      sh_we  = 1'b1;
      sh_idx = cnt_q + CW'(1);
    end else if (state_q == ST_SET) begin
      state_d = fifo_empty ? ST_IDLE : ST_LOAD;
      last_d  = 1'b0;
    end else if (last_q) begin
      // A last entry's final strobe is always followed by its own SET slot
      state_d  = ST_SET;
      set_d    = 1'b1;
      take_set = 1'b1;
      last_d   = 1'b0;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      last_d   = head_last;
      data_d   = head_data;
      if (&head_lane) begin
        state_d = ST_BCAST;
        cnt_d   = '0;
        sh_we   = 1'b1;
      end else if (head_lane < LANE_LIMIT) begin
        state_d = ST_LOAD;
        sh_we   = 1'b1;
        sh_idx  = CW'(head_lane);
      end else begin
        err_set  = 1'b1;
        data_d   = dly_data;
        last_d   = 1'b0;
        state_d  = head_last ? ST_SET : ST_LOAD;
        set_d    = head_last;
        take_set = head_last;
      end
    end else if (pend_eff) begin
      state_d  = ST_SET;
      set_d    = 1'b1;
      take_set = 1'b1;
    end else begin
      state_d = ST_IDLE;
    end
    ld_d       = sh_we ? (LANE0 << sh_idx) : '0;
    set_pend_d = pend_eff & ~take_set;
    busy_d     = (state_d != ST_IDLE) | fifo_push | (fifo_level > {{FAW{1'b0}}, fifo_pop});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      set_pend_q <= 1'b0;
      ld_dly     <= '0;
      dly_data   <= '0;
      set_dly    <= 1'b0;
      busy       <= 1'b0;
      err_lane   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      set_pend_q <= set_pend_d;
      ld_dly     <= ld_d;
      dly_data   <= data_d;
      set_dly    <= set_d;
      busy       <= busy_d;
      err_lane   <= err_lane | err_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) shadow[i] <= '0;
    end else if (sh_we) begin
      shadow[sh_idx] <= data_d;
    end
  end

  assign rd_data = (rd_lane < LANE_LIMIT) ? shadow[CW'(rd_lane)] : '0;

endmodule

// File: tb/tb_cmd_addr_dly_seq.sv
// Directed plus randomized bench; expected strobe/set stream comes from a request-level event queue.
module tb_cmd_addr_dly_seq;
  import cmd_addr_pkg::*;

  localparam int N = 23;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_last, set_req;
  logic [5:0]    req_lane, rd_lane;
  logic [7:0]    req_data, dly_data, rd_data;
  logic [N-1:0]  ld_dly;
  logic          set_dly, busy, err_lane;

  always #5 clk = ~clk;

  cmd_addr_dly_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_lane(req_lane), .req_data(req_data), .req_last(req_last), .set_req(set_req),
    .ld_dly(ld_dly), .dly_data(dly_data), .set_dly(set_dly), .busy(busy),
    .err_lane(err_lane), .rd_lane(rd_lane), .rd_data(rd_data)
  );

  typedef struct {bit is_set; int lane; logic [7:0] data;} ev_t;

  int         checks = 0;
  int         errors = 0;
  ev_t        exp_q[$];
  ev_t        mon_ev;
  logic [7:0] sh_m [N];
  bit         err_m;
  bit         mon_en;
  int         cyc;
  int         log_lane[$];
  int         log_cyc[$];
  int         w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request-level model: each accepted request expands into its strobes and an optional set
  task automatic model_push(input logic [5:0] l, input logic [7:0] d, input bit lst);
    if (l < N) begin
      exp_q.push_back('{1'b0, int'(l), d});
      sh_m[l] = d;
    end else if (l == BCAST) begin
      for (int i = 0; i < N; i++) begin
        exp_q.push_back('{1'b0, i, d});
        sh_m[i] = d;
      end
    end else begin
      err_m = 1'b1;
    end
    if (lst) exp_q.push_back('{1'b1, 0, 8'h00});
  endtask

  task automatic push(input logic [5:0] l, input logic [7:0] d, input bit lst, output int waited);
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1; req_lane = l; req_data = d; req_last = lst;
    while (!req_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    chk("push_ready", req_ready, 1'b1);
    if (req_ready) model_push(l, d, lst);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_last  = 1'b0;
    end
  endtask

  task automatic wait_ld(input int lane, input int budget);
    int g = 0;
    while (ld_dly !== (23'd1 << lane) && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk("wait_ld", ld_dly, 23'd1 << lane);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_q", exp_q.size(), 0);
    chk("drain_busy", busy, 1'b0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en && rst_n) begin
      chk("overlap", 32'(set_dly & (ld_dly != '0)), 0);
      chk("onehot", 32'($countones(ld_dly) <= 1), 1);
      if (ld_dly != '0) begin
        log_lane.push_back($clog2(ld_dly));
        log_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_strobe", ld_dly, 0);
        else begin
          mon_ev = exp_q.pop_front();
          chk("strobe_kind", mon_ev.is_set, 1'b0);
          chk("strobe_lane", ld_dly, 23'd1 << mon_ev.lane);
          chk("strobe_data", dly_data, mon_ev.data);
        end
      end
      if (set_dly) begin
        if (exp_q.size() == 0) chk("unexpected_set", set_dly, 0);
        else begin
          mon_ev = exp_q.pop_front();
          chk("set_kind", mon_ev.is_set, 1'b1);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_lane = '0; req_data = '0; req_last = 1'b0;
    set_req = 1'b0; rd_lane = '0; mon_en = 1'b0; err_m = 1'b0; cyc = 0;
    for (int i = 0; i < N; i++) sh_m[i] = '0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_ld", ld_dly, 0);
    chk("rst_data", dly_data, 0);
    chk("rst_set", set_dly, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_lane, 0);
    chk("rst_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Single lane write: strobe two cycles after acceptance, set right after
    push(6'd3, 8'h2A, 1'b1, w);
    idle(1);
    chk("t1_ld_t1", ld_dly, 0);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_ld_t2", ld_dly, 23'd1 << 3);
    chk("t1_data", dly_data, 8'h2A);
    chk("t1_set_t2", set_dly, 0);
    @(negedge clk);
    chk("t1_set_t3", set_dly, 1);
    chk("t1_ld_t3", ld_dly, 0);
    rd_lane = 6'd3;
    #1 chk("t1_rd", rd_data, 8'h2A);

    // Broadcast: every lane in order, then one set
    push(BCAST, 8'h11, 1'b1, w);
    idle(1);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("t2_seq", ld_dly, 23'd1 << i);
    end
    @(negedge clk);
    chk("t2_set", set_dly, 1);
    @(negedge clk);
    chk("t2_set_once", set_dly, 0);
    for (int i = 0; i < N; i++) begin
      rd_lane = 6'(i);
      #1 chk("t2_shadow", rd_data, 8'h11);
    end
    rd_lane = 6'd30;
    #1 chk("t2_rd_oor", rd_data, 0);
    rd_lane = BCAST;
    #1 chk("t2_rd_bcast", rd_data, 0);

    // Queue fills behind a broadcast; strobes then run back-to-back
    drain();
    log_lane.delete();
    log_cyc.delete();
    push(BCAST, 8'h77, 1'b0, w);
    for (int k = 0; k < 6; k++) begin
      push(6'(k), 8'h30 + 8'(k), 1'b0, w);
      if (k == 4) chk("t3_backpressure", 32'(w > 0), 1);
    end
    idle(1);
    drain();
    chk("t3_count", log_lane.size(), 29);
    for (int j = 0; j < 29 && j < log_lane.size(); j++) begin
      chk("t3_order", log_lane[j], (j < N) ? j : j - N);
      if (j > 0) chk("t3_b2b", log_cyc[j] - log_cyc[j-1], 1);
    end

    // Unused lane code: no strobe, sticky error, set still issued
    push(6'd40, 8'h5A, 1'b1, w);
    idle(1);
    chk("t4_no_ld", ld_dly, 0);
    @(negedge clk);
    chk("t4_set", set_dly, 1);
    chk("t4_no_ld2", ld_dly, 0);
    chk("t4_err", err_lane, 1);
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", err_lane, 1);

    // Manual set during a broadcast waits for the final strobe
    push(BCAST, 8'h55, 1'b0, w);
    idle(3);
    @(negedge clk);
    set_req = 1'b1;
    exp_q.push_back('{1'b1, 0, 8'h00});
    @(negedge clk);
    set_req = 1'b0;
    wait_ld(LANE_ODT, 100);
    @(negedge clk);
    chk("t5_set", set_dly, 1);
    chk("t5_no_ld", ld_dly, 0);
    @(negedge clk);
    chk("t5_set_once", set_dly, 0);
    drain();

    // Reset in the middle of a broadcast
    push(BCAST, 8'h99, 1'b0, w);
    idle(1);
    wait_ld(7, 50);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_ld", ld_dly, 0);
    chk("t6_set", set_dly, 0);
    chk("t6_busy", busy, 0);
    chk("t6_data", dly_data, 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) sh_m[i] = '0;
    err_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_busy_rel", busy, 0);
    chk("t6_err_rel", err_lane, 0);
    chk("t6_ld_rel", ld_dly, 0);
    for (int i = 0; i < N; i++) begin
      rd_lane = 6'(i);
      #1 chk("t6_shadow", rd_data, 0);
    end

    // Randomized traffic against the event model
    for (int i = 0; i < 120; i++) begin
      int r;
      logic [5:0] l;
      r = $urandom_range(0, 99);
      if (r < 75)      l = 6'($urandom_range(0, N - 1));
      else if (r < 88) l = BCAST;
      else             l = 6'($urandom_range(N, 62));
      push(l, 8'($urandom), ($urandom_range(0, 3) == 0), w);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(1);
    drain();
    for (int i = 0; i < N; i++) begin
      rd_lane = 6'(i);
      #1 chk("rand_shadow", rd_data, sh_m[i]);
    end
    chk("rand_err", err_lane, err_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
